pll_lock_supervisor: RTL
========================

// Module: pll_lock_supervisor
// PURPOSE
//  Sequences a single-output PLL: holds the PLL in reset, waits for lock, qualifies lock as stable, then releases
//  the downstream system reset. Detects loss of lock, re-resets the PLL with bounded retries, flags a fault.
//  Runs in the PLL reference-clock domain; sits between board reset and the PLL / user-logic reset tree.
// PARAMETERS
//  RST_CYCLES    16     cycles pll_rst is held high per reset attempt (>=1)
//  LOCK_TIMEOUT  65535  cycles to wait for synchronized lock before a retry (>=1)
//  STABLE_CYCLES 1024   consecutive locked cycles required before sys_rst_n releases (>=1)
//  MAX_RETRIES   3      reset attempts after the first before FAULT (0..15)
//  CNT_W         17     width of shared cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)
// PORTS
//  refclk      in   1  reference clock, the only clock
//  rst_n       in   1  asynchronous active-low reset
//  pll_locked  in   1  PLL locked, asynchronous to refclk
//  relock_req  in   1  single-cycle pulse: force a fresh PLL reset sequence
//  pll_rst     out  1  active-high reset to the PLL
//  sys_rst_n   out  1  active-low reset to logic clocked by the PLL output
//  ready       out  1  high in RUN
//  fault       out  1  high in FAULT (sticky until rst_n or relock_req)
//  retry_cnt   out  4  attempts used in the current sequence
//  loss_cnt    out  8  saturating count of lock-loss events (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=PLL_RST, counter=0, pll_rst=1, sys_rst_n=0, ready=0, fault=0, retry_cnt=0,
//    loss_cnt=0, sync flops=0. Deassertion is not resynchronized internally; board reset is already synchronous-released.
//  - pll_locked passes a 2-flop synchronizer -> lock_s; all decisions use lock_s (2-cycle input latency).
//  - States (one counter, cleared on every state entry):
//    PLL_RST : pll_rst=1; after RST_CYCLES cycles -> WAIT_LOCK.
//    WAIT_LOCK: pll_rst=0; lock_s=1 -> STABLE. Counter reaches LOCK_TIMEOUT with lock_s=0:
//              retry_cnt<MAX_RETRIES -> retry_cnt+1, PLL_RST; else -> FAULT.
//    STABLE  : lock_s=0 -> WAIT_LOCK (counter cleared, no retry consumed). STABLE_CYCLES consecutive
//              lock_s=1 -> RUN.
//    RUN     : sys_rst_n=1, ready=1. lock_s=0 -> loss event: sys_rst_n=0 and ready=0 on the next edge,
//              retry_cnt=0, -> PLL_RST.
//    FAULT   : pll_rst=1, sys_rst_n=0, fault=1; holds until rst_n or relock_req.
//  - All outputs registered; pll_rst, sys_rst_n, ready, fault are decoded from next-state so they change on the
//    same edge as the state.
//  - relock_req in any state: next state PLL_RST, retry_cnt=0, fault=0, counter=0. Has priority over all
//    other transitions in the same cycle, including RUN lock loss (counted as a relock, not a loss).
//  - Glitch on pll_locked shorter than one refclk period may be missed; not a requirement to catch.
//  - Timing: pll_rst high exactly RST_CYCLES cycles. sys_rst_n rises STABLE_CYCLES+1 cycles after lock_s rises
//    (STABLE_CYCLES+3 after the raw pll_locked rise).
//  - retry_cnt saturates at MAX_RETRIES; it is never incremented past it.
// CONFIGURATION
//  PLL_LOSS_COUNT_EN defined: loss_cnt increments by 1 per RUN->PLL_RST lock-loss event, saturates at 255,
//    cleared only by rst_n (not by relock_req).
//  PLL_LOSS_COUNT_EN undefined: no counter register; loss_cnt tied to 8'd0; all other behaviour identical.
// TESTING  (bench uses RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
//  1 Release rst_n, raise pll_locked 10 cycles later and hold -> pll_rst high exactly 4 cycles; sys_rst_n and ready
//    rise 11 cycles after the pll_locked rise; fault=0, retry_cnt=0.
//  2 pll_locked held 0 -> three pll_rst pulses of 4 cycles, 20-cycle waits between; retry_cnt 0->1->2; then fault=1,
//    pll_rst=1, sys_rst_n=0 indefinitely.
//  3 In FAULT pulse relock_req, then lock -> fault clears next edge, retry_cnt=0, normal sequence to RUN as in 1.
//  4 In STABLE drop pll_locked for 3 cycles at stable count 5 -> returns to WAIT_LOCK, no retry consumed; after
//    relock, sys_rst_n needs a full 8 fresh locked cycles.
//  5 In RUN drop pll_locked for 2 cycles -> ready/sys_rst_n fall 3 edges after drop, pll_rst pulses 4 cycles;
//    loss_cnt=1 with PLL_LOSS_COUNT_EN, 0 without; 300 losses -> loss_cnt=255.
//  6 Assert rst_n=0 mid-WAIT_LOCK with retry_cnt=1 -> all outputs to reset values asynchronously, before next edge.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//
// Sequences a single-output PLL from board reset to a running system:
//   1. holds the PLL in reset for a fixed number of reference-clock cycles,
//   2. waits (bounded) for the synchronized lock indication,
//   3. qualifies lock as stable for a run of consecutive locked cycles,
//   4. releases the downstream system reset and reports ready.
// A lock loss while running restarts the whole sequence. A lock timeout
// retries the PLL reset a bounded number of times and then parks in FAULT.
// A relock request restarts the sequence from any state, including FAULT.
//
// Everything runs in the reference-clock domain. The PLL lock input is
// asynchronous and passes a two-flop synchronizer before any decision uses
// it, so every lock-dependent reaction lags the raw input by two cycles.
//
// Parameters
//   RST_CYCLES    cycles pll_rst is held high per reset attempt (>=1)
//   LOCK_TIMEOUT  cycles to wait for lock before a retry (>=1)
//   STABLE_CYCLES consecutive locked cycles required before release (>=1)
//   MAX_RETRIES   reset attempts after the first before FAULT (0..15)
//   CNT_W         width of the shared cycle counter; must be able to hold
//                 the largest of RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES
//
// Ports
//   refclk      in   1  reference clock, the only clock
//   rst_n       in   1  asynchronous active-low reset (release already synced)
//   pll_locked  in   1  PLL lock flag, asynchronous to refclk
//   relock_req  in   1  single-cycle pulse forcing a fresh PLL reset sequence
//   pll_rst     out  1  active-high reset to the PLL
//   sys_rst_n   out  1  active-low reset to logic clocked by the PLL output
//   ready       out  1  high while running with a qualified lock
//   fault       out  1  high in FAULT (sticky until rst_n or relock_req)
//   retry_cnt   out  4  reset attempts used in the current sequence
//   loss_cnt    out  8  saturating count of lock-loss events while running
//
// Configuration macro
//   PLL_LOSS_COUNT_EN  when defined, loss_cnt counts RUN lock-loss events
//                      (saturating at 255, cleared only by rst_n). When not
//                      defined there is no counter register and loss_cnt
//                      is tied to zero.
// ---------------------------------------------------------------------------

module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 17
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  // Terminal counter values. The counter is cleared on the edge that enters
  // a state, so a state that must last N cycles leaves when the counter
  // shows N-1.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retryCnt_q, retryCnt_d;
  logic             sync1_q, sync2_q;
  logic             pllRst_q, pllRst_d;
  logic             sysRstN_q, sysRstN_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             lockS;

  // Two-flop synchronizer for the asynchronous lock flag. Only the second
  // stage is ever looked at by the sequencer.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  assign lockS = sync2_q;

  // Next-state logic. A relock request overrides every other transition,
  // including a lock loss in RUN in the same cycle, which is then treated
  // purely as a relock. The retry count only moves on a lock timeout and is
  // guarded so it can never pass MAX_RETRIES.
  always_comb begin
    state_d    = state_q;
    retryCnt_d = retryCnt_q;

    if (relock_req) begin
      state_d    = ST_PLL_RST;
      retryCnt_d = 4'd0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
          end
        end

        ST_WAIT_LOCK: begin
          if (lockS) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retryCnt_q < RETRY_MAX) begin
              retryCnt_d = retryCnt_q + 4'd1;
              state_d    = ST_PLL_RST;
            end else begin
              state_d = ST_FAULT;
            end
          end
        end

        ST_STABLE: begin
          if (!lockS) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
          end
        end

        ST_RUN: begin
          if (!lockS) begin
            state_d    = ST_PLL_RST;
            retryCnt_d = 4'd0;
          end
        end

        ST_FAULT: begin
          state_d = ST_FAULT;
        end

        default: begin
          state_d = ST_PLL_RST;
        end
      endcase
    end
  end

  // Shared cycle counter. It restarts from zero on every state entry; a
  // relock request while already in PLL_RST is also an entry even though
  // the state code does not change. RUN and FAULT have no time limit, so
  // the counter is parked at zero there instead of free-running.
  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
    if (relock_req || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == ST_RUN) || (state_q == ST_FAULT)) begin
      cnt_d = '0;
    end
  end

  // Output decode from the next state, so the registered outputs change on
  // the same edge as the state register rather than one cycle later.
  always_comb begin
    pllRst_d  = (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
    sysRstN_d = (state_d == ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fault_d   = (state_d == ST_FAULT);
  end

  // State, counter, retry count and registered outputs. The reset values
  // hold the PLL and the downstream logic in reset.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_PLL_RST;
      cnt_q      <= '0;
      retryCnt_q <= 4'd0;
      pllRst_q   <= 1'b1;
      sysRstN_q  <= 1'b0;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retryCnt_q <= retryCnt_d;
      pllRst_q   <= pllRst_d;
      sysRstN_q  <= sysRstN_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
    end
  end

  assign pll_rst   = pllRst_q;
  assign sys_rst_n = sysRstN_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retryCnt_q;

`ifdef PLL_LOSS_COUNT_EN
  logic [7:0] lossCnt_q, lossCnt_d;
  logic       lossEvent;

  // A loss event is a lock drop seen while running that is not masked by a
  // simultaneous relock request. The count saturates and survives relocks.
  assign lossEvent = (state_q == ST_RUN) && !lockS && !relock_req;

  always_comb begin
    lossCnt_d = lossCnt_q;
    if (lossEvent && (lossCnt_q != 8'hFF)) begin
      lossCnt_d = lossCnt_q + 8'd1;
    end
  end

  // Loss counter register, cleared only by the board reset.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lossCnt_q <= 8'd0;
    end else begin
      lossCnt_q <= lossCnt_d;
    end
  end

  assign loss_cnt = lossCnt_q;
`else
  assign loss_cnt = 8'd0;
`endif

endmodule
